// File: rtl/sat_accum_16_pkg.sv
// Shared definitions for the saturating accumulator: FSM encoding and
// the signed 16-bit saturation limits.
package sat_accum_16_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/sat_accum_16_adder.sv
// 16-bit signed saturating adder: clamps to SAT_POS/SAT_NEG when two
// like-signed operands produce a sum of the opposite sign.
module sat_accum_16_adder
    import sat_accum_16_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Sum,
    output logic        Ovfl
);

    logic [15:0] raw;

    assign raw = A + B;

    always_comb begin
        Sum  = raw;
        Ovfl = 1'b0;
        if (A[15] && B[15] && !raw[15]) begin
            Sum  = SAT_NEG;
            Ovfl = 1'b1;
        end else if (!A[15] && !B[15] && raw[15]) begin
            Sum  = SAT_POS;
            Ovfl = 1'b1;
        end
    end

endmodule

// File: rtl/sat_accum_16.sv
// Multi-cycle saturating accumulator for vector sum/reduction ops; emits
// the saturated total with N/Z/V flags once per start.
module sat_accum_16
    import sat_accum_16_pkg::*;
#(
    parameter int          CNT_W    = 8,
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: an operand transfers on a cycle where in_valid && in_ready;
    // the result transfers on out_valid && out_ready. Once out_valid is high,
    // result and flags hold until that transfer.

    state_e           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             v_sticky;
    logic [15:0]      add_sum;
    logic             add_ovfl;

    sat_accum_16_adder u_adder (
        .A    (acc),
        .B    (in_data),
        .Sum  (add_sum),
        .Ovfl (add_ovfl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= ACC_INIT;
            cnt      <= '0;
            v_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= ACC_INIT;
                        v_sticky <= 1'b0;
                        if (count != '0) begin
                            cnt   <= count;
                            state <= S_ACC;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        acc      <= add_sum;
                        v_sticky <= v_sticky | add_ovfl;
                        cnt      <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                // The unused fourth encoding falls back to IDLE.
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    assign result = acc;
    assign flag_n = acc[15];
    assign flag_z = (acc == 16'h0000);
    assign flag_v = v_sticky;

endmodule
